// File: rtl/mem_types_pkg.sv
// rtl/mem_types_pkg.sv - shared types for the memory arbiter and its RAM interface
package mem_types_pkg;

    localparam int WORD_W = 32;

    // Handshake state reported by the RAM for the current access
    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    // Arbiter grant state
    typedef enum logic [1:0] {
        IDLE,
        D_ACC,
        I_ACC
    } arb_state_t;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - arbitrates fetch and data requests onto one single-ported RAM
module memory_arbiter #(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dhit,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              err
);

    import mem_types_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t       state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic             last_d, next_last_d;
    logic             next_err;
    ramstate_t        ram_st;
    logic             d_req;
    logic             timed_out;

    assign ram_st    = ramstate_t'(ramstate);
    assign d_req     = dREN | dWEN;
    assign timed_out = (cnt == CNT_W'(TIMEOUT));

    // State, wait counter, fairness flag and sticky error register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            last_d <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= next_state;
            cnt    <= next_cnt;
            last_d <= next_last_d;
            err    <= next_err;
        end
    end

    // Arbitration, RAM drive, completion and abandon decisions
    always_comb begin
        next_state  = state;
        next_cnt    = cnt;
        next_last_d = last_d;
        next_err    = err;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        ihit        = 1'b0;
        dhit        = 1'b0;
        iload       = '0;
        dload       = '0;

        case (state)
            IDLE: begin
                next_cnt = '0;
                // data first, unless a fetch is waiting right after a data hit
                if (d_req && !(iREN && last_d)) begin
                    next_state = D_ACC;
                end else if (iREN) begin
                    next_state = I_ACC;
                end
            end

            D_ACC: begin
                ramaddr = daddr;
                // write wins when both enables are held
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore;
                end else begin
                    ramREN = 1'b1;
                end
                if (!d_req) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else if (timed_out || ram_st == ERROR) begin
                    next_err   = 1'b1;
                    next_state = IDLE;
                    next_cnt   = '0;
                end else if (ram_st == ACCESS) begin
                    dhit        = 1'b1;
                    dload       = ramload;
                    next_state  = IDLE;
                    next_cnt    = '0;
                    next_last_d = 1'b1;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end

            I_ACC: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (!iREN) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else if (timed_out || ram_st == ERROR) begin
                    next_err   = 1'b1;
                    next_state = IDLE;
                    next_cnt   = '0;
                end else if (ram_st == ACCESS) begin
                    ihit        = 1'b1;
                    iload       = ramload;
                    next_state  = IDLE;
                    next_cnt    = '0;
                    next_last_d = 1'b0;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end

            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

endmodule
